// File: rtl/execute_mul_unit_pkg.sv
// Shared types for the RV32M multiply execution lane: issue/write-back packs,
// feedback channels and the operation encodings they carry.
package execute_mul_unit_pkg;

    localparam int MUL_UNIT_NUM        = 1;
    localparam int XLEN                = 32;
    localparam int ARCH_REG_ID_WIDTH   = 5;
    localparam int PHY_REG_ID_WIDTH    = 6;
    localparam int ROB_ID_WIDTH        = 4;
    localparam int CHECKPOINT_ID_WIDTH = 3;
    localparam int CSR_ADDR_WIDTH      = 12;

    typedef enum logic [1:0] {
        arg_src_reg     = 2'd0,
        arg_src_imm     = 2'd1,
        arg_src_disable = 2'd2
    } arg_src_t;

    typedef enum logic [3:0] {
        op_alu    = 4'd0,
        op_branch = 4'd1,
        op_jump   = 4'd2,
        op_load   = 4'd3,
        op_store  = 4'd4,
        op_csr    = 4'd5,
        op_mul    = 4'd6,
        op_div    = 4'd7
    } op_t;

    typedef enum logic [2:0] {
        op_unit_alu = 3'd0,
        op_unit_bru = 3'd1,
        op_unit_csr = 3'd2,
        op_unit_mul = 3'd3,
        op_unit_lsu = 3'd4
    } op_unit_t;

    // Encodings 4..7 are not multiply operations and yield a zero result.
    typedef enum logic [2:0] {
        mul_op_mul    = 3'd0,
        mul_op_mulh   = 3'd1,
        mul_op_mulhsu = 3'd2,
        mul_op_mulhu  = 3'd3
    } mul_op_t;

    typedef enum logic [3:0] {
        instruction_address_misaligned = 4'd0,
        instruction_access_fault       = 4'd1,
        illegal_instruction            = 4'd2,
        breakpoint                     = 4'd3,
        load_address_misaligned        = 4'd4,
        load_access_fault              = 4'd5
    } riscv_exception_t;

    typedef struct packed {
        mul_op_t mul_op;
    } sub_op_t;

    typedef struct packed {
        logic                           enable;
        logic [31:0]                    value;
        logic                           valid;
        logic [ROB_ID_WIDTH-1:0]        rob_id;
        logic [XLEN-1:0]                pc;
        logic [XLEN-1:0]                imm;
        logic                           has_exception;
        riscv_exception_t               exception_id;
        logic [XLEN-1:0]                exception_value;
        logic                           predicted;
        logic                           predicted_jump;
        logic [XLEN-1:0]                predicted_next_pc;
        logic                           checkpoint_id_valid;
        logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
        logic [ARCH_REG_ID_WIDTH-1:0]   rs1;
        arg_src_t                       arg1_src;
        logic                           rs1_need_map;
        logic [PHY_REG_ID_WIDTH-1:0]    rs1_phy;
        logic [XLEN-1:0]                src1_value;
        logic                           src1_loaded;
        logic [ARCH_REG_ID_WIDTH-1:0]   rs2;
        arg_src_t                       arg2_src;
        logic                           rs2_need_map;
        logic [PHY_REG_ID_WIDTH-1:0]    rs2_phy;
        logic [XLEN-1:0]                src2_value;
        logic                           src2_loaded;
        logic [ARCH_REG_ID_WIDTH-1:0]   rd;
        logic                           rd_enable;
        logic                           need_rename;
        logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
        logic [CSR_ADDR_WIDTH-1:0]      csr;
        op_t                            op;
        op_unit_t                       op_unit;
        sub_op_t                        sub_op;
    } issue_execute_pack_t;

    typedef struct packed {
        logic                           enable;
        logic [31:0]                    value;
        logic                           valid;
        logic [ROB_ID_WIDTH-1:0]        rob_id;
        logic [XLEN-1:0]                pc;
        logic [XLEN-1:0]                imm;
        logic                           has_exception;
        riscv_exception_t               exception_id;
        logic [XLEN-1:0]                exception_value;
        logic                           predicted;
        logic                           predicted_jump;
        logic [XLEN-1:0]                predicted_next_pc;
        logic                           checkpoint_id_valid;
        logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
        logic                           bru_jump;
        logic [XLEN-1:0]                bru_next_pc;
        logic [ARCH_REG_ID_WIDTH-1:0]   rs1;
        arg_src_t                       arg1_src;
        logic                           rs1_need_map;
        logic [PHY_REG_ID_WIDTH-1:0]    rs1_phy;
        logic [XLEN-1:0]                src1_value;
        logic                           src1_loaded;
        logic [ARCH_REG_ID_WIDTH-1:0]   rs2;
        arg_src_t                       arg2_src;
        logic                           rs2_need_map;
        logic [PHY_REG_ID_WIDTH-1:0]    rs2_phy;
        logic [XLEN-1:0]                src2_value;
        logic                           src2_loaded;
        logic [ARCH_REG_ID_WIDTH-1:0]   rd;
        logic                           rd_enable;
        logic                           need_rename;
        logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
        logic [XLEN-1:0]                rd_value;
        logic [CSR_ADDR_WIDTH-1:0]      csr;
        logic                           csr_newvalue_valid;
        logic [XLEN-1:0]                csr_newvalue;
        op_t                            op;
        op_unit_t                       op_unit;
        sub_op_t                        sub_op;
    } execute_wb_pack_t;

    typedef struct packed {
        logic                        enable;
        logic [PHY_REG_ID_WIDTH-1:0] phy_id;
        logic [XLEN-1:0]             value;
    } execute_feedback_channel_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;

    // rs1 is sign-extended for mulh and mulhsu.
    function automatic logic mul_src1_signed(input mul_op_t op);
        return (op == mul_op_mulh) || (op == mul_op_mulhsu);
    endfunction

    // rs2 is sign-extended only for mulh.
    function automatic logic mul_src2_signed(input mul_op_t op);
        return (op == mul_op_mulh);
    endfunction

endpackage

// File: rtl/execute_mul_unit_if.sv
// Bundle between the multiply lane and its neighbours: issue FIFO head,
// commit feedback, write-back port and execute feedback broadcast.
// Handshake: the FIFO head is consumed in any cycle where pop is high; pop is
// only raised when data_out_valid is high. The write-back port has no ready and
// accepts every cycle in which we is high.
interface execute_mul_unit_if;
    import execute_mul_unit_pkg::*;

    issue_execute_pack_t       issue_mul_fifo_data_out;
    logic                      issue_mul_fifo_data_out_valid;
    logic                      issue_mul_fifo_pop;
    execute_wb_pack_t          mul_wb_port_data_in;
    logic                      mul_wb_port_we;
    logic                      mul_wb_port_flush;
    execute_feedback_channel_t mul_execute_channel_feedback_pack;
    commit_feedback_pack_t     commit_feedback_pack;

    // Environment side: drives the FIFO head and commit feedback.
    modport master (
        output issue_mul_fifo_data_out,
        output issue_mul_fifo_data_out_valid,
        input  issue_mul_fifo_pop,
        input  mul_wb_port_data_in,
        input  mul_wb_port_we,
        input  mul_wb_port_flush,
        input  mul_execute_channel_feedback_pack,
        output commit_feedback_pack
    );

    // Execute-unit side.
    modport slave (
        input  issue_mul_fifo_data_out,
        input  issue_mul_fifo_data_out_valid,
        output issue_mul_fifo_pop,
        output mul_wb_port_data_in,
        output mul_wb_port_we,
        output mul_wb_port_flush,
        output mul_execute_channel_feedback_pack,
        input  commit_feedback_pack
    );

endinterface

// File: rtl/execute_mul_unit_mul_core.sv
// 33x33 signed multiplier: each operand gets a 33rd bit that is its sign bit
// or zero depending on the op, so one signed multiply covers all four RV32M
// multiply flavours.
module execute_mul_unit_mul_core
    import execute_mul_unit_pkg::*;
(
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  mul_op_t         mul_op_i,
    output logic [XLEN-1:0] result_o
);

    logic signed [32:0] src1_ext;
    logic signed [32:0] src2_ext;
    logic signed [63:0] product;

    // Extend operands per op, multiply, and pick the low or high word.
    always_comb begin
        src1_ext = {mul_src1_signed(mul_op_i) & src1_i[31], src1_i};
        src2_ext = {mul_src2_signed(mul_op_i) & src2_i[31], src2_i};
        product  = 64'(src1_ext) * 64'(src2_ext);
        result_o = '0;
        case (mul_op_i)
            mul_op_mul:    result_o = product[31:0];
            mul_op_mulh:   result_o = product[63:32];
            mul_op_mulhsu: result_o = product[63:32];
            mul_op_mulhu:  result_o = product[63:32];
            default:       result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_mul_unit.sv
// Single-cycle RV32M multiply lane. Pops the issue FIFO head whenever one is
// present and no flush is pending, and hands the finished pack to write-back
// and the execute feedback channel in the same cycle. No internal state.
module execute_mul_unit
    import execute_mul_unit_pkg::*;
(
    input logic               clk,
    input logic               rst,
    execute_mul_unit_if.slave mul_if
);

    issue_execute_pack_t pack_in;
    execute_wb_pack_t    wb;
    logic                flush_req;
    logic                pop;
    logic                fb_enable;
    logic [XLEN-1:0]     mul_result;

    assign pack_in = mul_if.issue_mul_fifo_data_out;

    execute_mul_unit_mul_core u_mul_core (
        .src1_i   (pack_in.src1_value),
        .src2_i   (pack_in.src2_value),
        .mul_op_i (pack_in.sub_op.mul_op),
        .result_o (mul_result)
    );

    // Handshake control: flush beats a valid head, reset silences everything.
    always_comb begin
        flush_req = mul_if.commit_feedback_pack.enable & mul_if.commit_feedback_pack.flush;
        pop       = !rst & !flush_req & mul_if.issue_mul_fifo_data_out_valid;
        mul_if.issue_mul_fifo_pop = pop;
        mul_if.mul_wb_port_we     = pop;
        mul_if.mul_wb_port_flush  = !rst & flush_req;
    end

    // Build the write-back pack: copy the issue pack, clear branch/CSR results,
    // and attach the multiply result only for a live, non-faulting instruction.
    always_comb begin
        wb = '0;
        if (pop) begin
            wb.enable              = pack_in.enable;
            wb.value               = pack_in.value;
            wb.valid               = pack_in.valid;
            wb.rob_id              = pack_in.rob_id;
            wb.pc                  = pack_in.pc;
            wb.imm                 = pack_in.imm;
            wb.has_exception       = pack_in.has_exception;
            wb.exception_id        = pack_in.exception_id;
            wb.exception_value     = pack_in.exception_value;
            wb.predicted           = pack_in.predicted;
            wb.predicted_jump      = pack_in.predicted_jump;
            wb.predicted_next_pc   = pack_in.predicted_next_pc;
            wb.checkpoint_id_valid = pack_in.checkpoint_id_valid;
            wb.checkpoint_id       = pack_in.checkpoint_id;
            wb.rs1                 = pack_in.rs1;
            wb.arg1_src            = pack_in.arg1_src;
            wb.rs1_need_map        = pack_in.rs1_need_map;
            wb.rs1_phy             = pack_in.rs1_phy;
            wb.src1_value          = pack_in.src1_value;
            wb.src1_loaded         = pack_in.src1_loaded;
            wb.rs2                 = pack_in.rs2;
            wb.arg2_src            = pack_in.arg2_src;
            wb.rs2_need_map        = pack_in.rs2_need_map;
            wb.rs2_phy             = pack_in.rs2_phy;
            wb.src2_value          = pack_in.src2_value;
            wb.src2_loaded         = pack_in.src2_loaded;
            wb.rd                  = pack_in.rd;
            wb.rd_enable           = pack_in.rd_enable;
            wb.need_rename         = pack_in.need_rename;
            wb.rd_phy              = pack_in.rd_phy;
            wb.csr                 = pack_in.csr;
            wb.op                  = pack_in.op;
            wb.op_unit             = pack_in.op_unit;
            wb.sub_op              = pack_in.sub_op;
            wb.bru_jump            = 1'b0;
            wb.bru_next_pc         = '0;
            wb.csr_newvalue_valid  = 1'b0;
            wb.csr_newvalue        = '0;
            if (pack_in.enable & pack_in.valid & !pack_in.has_exception) begin
                wb.rd_value = mul_result;
            end
        end
        mul_if.mul_wb_port_data_in = wb;
    end

    // Broadcast the renamed destination so waiting consumers can wake up.
    always_comb begin
        fb_enable = wb.enable & wb.valid & wb.rd_enable & wb.need_rename;
        mul_if.mul_execute_channel_feedback_pack.enable = fb_enable;
        mul_if.mul_execute_channel_feedback_pack.phy_id = fb_enable ? wb.rd_phy : '0;
        mul_if.mul_execute_channel_feedback_pack.value  = fb_enable ? wb.rd_value : '0;
    end

    // Reset must hold the FIFO untouched.
    a_no_pop_in_reset : assert property (@(posedge clk) rst |-> !mul_if.issue_mul_fifo_pop);

endmodule

// File: tb/tb_execute_mul_unit.sv
// Directed bench for the multiply lane: each vector is applied on the falling
// clock edge and the combinational outputs are sampled shortly afterwards.
module tb_execute_mul_unit;
    import execute_mul_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    execute_mul_unit_if bus_if ();

    execute_mul_unit dut (
        .clk    (clk),
        .rst    (rst),
        .mul_if (bus_if)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic issue_execute_pack_t make_pack(input mul_op_t op, input logic [31:0] a,
                                                      input logic [31:0] b);
        issue_execute_pack_t p;
        p = '0;
        p.enable              = 1'b1;
        p.valid               = 1'b1;
        p.value               = 32'h0273_02b3;
        p.rob_id              = 4'd9;
        p.pc                  = 32'h8000_0100;
        p.imm                 = 32'h0000_0abc;
        p.predicted           = 1'b1;
        p.predicted_next_pc   = 32'h8000_0104;
        p.checkpoint_id_valid = 1'b1;
        p.checkpoint_id       = 3'd2;
        p.rs1                 = 5'd6;
        p.rs2                 = 5'd7;
        p.arg1_src            = arg_src_reg;
        p.arg2_src            = arg_src_reg;
        p.rs1_need_map        = 1'b1;
        p.rs2_need_map        = 1'b1;
        p.rs1_phy             = 6'd11;
        p.rs2_phy             = 6'd12;
        p.src1_value          = a;
        p.src2_value          = b;
        p.src1_loaded         = 1'b1;
        p.src2_loaded         = 1'b1;
        p.rd                  = 5'd5;
        p.rd_enable           = 1'b1;
        p.need_rename         = 1'b1;
        p.rd_phy              = 6'd5;
        p.csr                 = 12'h300;
        p.op                  = op_mul;
        p.op_unit             = op_unit_mul;
        p.sub_op.mul_op       = op;
        return p;
    endfunction

    // Driver: apply one vector away from the rising edge and let it settle.
    task automatic drive(input issue_execute_pack_t p, input logic head_valid, input logic c_en,
                         input logic c_flush, input logic r);
        @(negedge clk);
        rst                                  = r;
        bus_if.issue_mul_fifo_data_out       = p;
        bus_if.issue_mul_fifo_data_out_valid = head_valid;
        bus_if.commit_feedback_pack.enable   = c_en;
        bus_if.commit_feedback_pack.flush    = c_flush;
        #2;
    endtask

    task automatic expect_outputs(input string tag, input logic pop, input logic flush,
                                  input logic [31:0] rd_value, input logic fb_en,
                                  input logic [5:0] fb_phy, input logic [31:0] fb_val);
        check({tag, ".pop"}, 64'(bus_if.issue_mul_fifo_pop), 64'(pop));
        check({tag, ".we"}, 64'(bus_if.mul_wb_port_we), 64'(pop));
        check({tag, ".flush"}, 64'(bus_if.mul_wb_port_flush), 64'(flush));
        check({tag, ".rd_value"}, 64'(bus_if.mul_wb_port_data_in.rd_value), 64'(rd_value));
        check({tag, ".fb_enable"}, 64'(bus_if.mul_execute_channel_feedback_pack.enable), 64'(fb_en));
        check({tag, ".fb_phy"}, 64'(bus_if.mul_execute_channel_feedback_pack.phy_id), 64'(fb_phy));
        check({tag, ".fb_value"}, 64'(bus_if.mul_execute_channel_feedback_pack.value), 64'(fb_val));
        if (!pop) begin
            check({tag, ".wb_nonzero"}, 64'(|bus_if.mul_wb_port_data_in), 64'd0);
        end
    endtask

    task automatic expect_pass_through(input string tag, input issue_execute_pack_t p);
        check({tag, ".pc"}, 64'(bus_if.mul_wb_port_data_in.pc), 64'(p.pc));
        check({tag, ".rob_id"}, 64'(bus_if.mul_wb_port_data_in.rob_id), 64'(p.rob_id));
        check({tag, ".rd_phy"}, 64'(bus_if.mul_wb_port_data_in.rd_phy), 64'(p.rd_phy));
        check({tag, ".imm"}, 64'(bus_if.mul_wb_port_data_in.imm), 64'(p.imm));
        check({tag, ".src2"}, 64'(bus_if.mul_wb_port_data_in.src2_value), 64'(p.src2_value));
        check({tag, ".has_exc"}, 64'(bus_if.mul_wb_port_data_in.has_exception), 64'(p.has_exception));
        check({tag, ".exc_id"}, 64'(bus_if.mul_wb_port_data_in.exception_id), 64'(p.exception_id));
        check({tag, ".ckpt"}, 64'(bus_if.mul_wb_port_data_in.checkpoint_id), 64'(p.checkpoint_id));
        check({tag, ".pred_pc"}, 64'(bus_if.mul_wb_port_data_in.predicted_next_pc), 64'(p.predicted_next_pc));
        check({tag, ".sub_op"}, 64'(bus_if.mul_wb_port_data_in.sub_op), 64'(p.sub_op));
        check({tag, ".op_unit"}, 64'(bus_if.mul_wb_port_data_in.op_unit), 64'(p.op_unit));
        check({tag, ".bru_jump"}, 64'(bus_if.mul_wb_port_data_in.bru_jump), 64'd0);
        check({tag, ".bru_pc"}, 64'(bus_if.mul_wb_port_data_in.bru_next_pc), 64'd0);
        check({tag, ".csr_nv"}, 64'(bus_if.mul_wb_port_data_in.csr_newvalue_valid), 64'd0);
        check({tag, ".csr_val"}, 64'(bus_if.mul_wb_port_data_in.csr_newvalue), 64'd0);
    endtask

    initial begin
        issue_execute_pack_t p;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus_if.issue_mul_fifo_data_out       = '0;
        bus_if.issue_mul_fifo_data_out_valid = 1'b0;
        bus_if.commit_feedback_pack          = '0;

        // Reset with a valid head and a pending flush: everything quiet.
        p = make_pack(mul_op_mul, 32'd7, 32'd6);
        drive(p, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_outputs("rst_flush", 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_outputs("rst_head", 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);

        // First cycle out of reset is live.
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mul_7x6", 1'b1, 1'b0, 32'd42, 1'b1, 6'd5, 32'd42);
        expect_pass_through("mul_7x6", p);

        // Multiply flavours at the sign boundaries.
        p = make_pack(mul_op_mulh, 32'h8000_0000, 32'h8000_0000);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mulh_min", 1'b1, 1'b0, 32'h4000_0000, 1'b1, 6'd5, 32'h4000_0000);
        p = make_pack(mul_op_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mulhu_max", 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 6'd5, 32'hFFFF_FFFE);
        p = make_pack(mul_op_mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mulhsu_max", 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 6'd5, 32'hFFFF_FFFF);
        p = make_pack(mul_op_mulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mulh_m1m1", 1'b1, 1'b0, 32'h0000_0000, 1'b1, 6'd5, 32'h0000_0000);
        p = make_pack(mul_op_mulh, 32'hFFFF_FFFF, 32'd2);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mulh_m1x2", 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 6'd5, 32'hFFFF_FFFF);
        p = make_pack(mul_op_mulhu, 32'h8000_0000, 32'd2);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mulhu_carry", 1'b1, 1'b0, 32'h0000_0001, 1'b1, 6'd5, 32'h0000_0001);
        p = make_pack(mul_op_mul, 32'hFFFF_FFFF, 32'd2);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mul_neg", 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 6'd5, 32'hFFFF_FFFE);
        p = make_pack(mul_op_mul, 32'h1234_5678, 32'h0000_1000);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("mul_shift", 1'b1, 1'b0, 32'h4567_8000, 1'b1, 6'd5, 32'h4567_8000);

        // Undefined mul_op encoding gives zero but still pops.
        p = make_pack(mul_op_mul, 32'd7, 32'd6);
        p.sub_op.mul_op = mul_op_t'(3'd5);
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("bad_op", 1'b1, 1'b0, 32'd0, 1'b1, 6'd5, 32'd0);

        // Flush coincident with a valid head.
        p = make_pack(mul_op_mul, 32'd7, 32'd6);
        drive(p, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_outputs("flush", 1'b0, 1'b1, 32'd0, 1'b0, 6'd0, 32'd0);

        // Flush bit without commit enable is ignored.
        drive(p, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_outputs("flush_no_en", 1'b1, 1'b0, 32'd42, 1'b1, 6'd5, 32'd42);

        // Empty FIFO.
        drive(p, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_outputs("empty", 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);

        // Faulting instruction passes through without a result.
        p = make_pack(mul_op_mul, 32'd7, 32'd6);
        p.has_exception   = 1'b1;
        p.exception_id    = illegal_instruction;
        p.exception_value = 32'h0273_02b3;
        p.rob_id          = 4'd3;
        p.valid           = 1'b0;
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("exception", 1'b1, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);
        expect_pass_through("exception", p);

        // Exception flag alone also suppresses the result.
        p.valid = 1'b1;
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("exc_valid", 1'b1, 1'b0, 32'd0, 1'b1, 6'd5, 32'd0);

        // Disabled slot: no result, no feedback.
        p = make_pack(mul_op_mul, 32'd7, 32'd6);
        p.enable = 1'b0;
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("disabled", 1'b1, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);

        // No rename: result computed, feedback suppressed.
        p = make_pack(mul_op_mul, 32'd9, 32'd9);
        p.need_rename = 1'b0;
        p.rd_phy      = 6'd17;
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("no_rename", 1'b1, 1'b0, 32'd81, 1'b0, 6'd0, 32'd0);

        // Different destination register on the feedback channel.
        p = make_pack(mul_op_mul, 32'd3, 32'd5);
        p.rd_phy = 6'd33;
        drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outputs("phy33", 1'b1, 1'b0, 32'd15, 1'b1, 6'd33, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
